// File: rtl/ff_ctrl.sv
// Writeback forwarding tracker: two independent shift pipes of in-flight results,
// each entry retiring to the register-file write port after a uid-dependent latency.

module ff_ctrl_pipe #(
    parameter int DEPTH     = 7,
    parameter int FLUSH_AGE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_i,
    input  logic       valid_i,
    input  logic [6:0] rtaddr_i,
    input  logic [2:0] uid_i,
    output logic       ready_o,
    output logic       nxt_valid_o,
    output logic [6:0] nxt_rtaddr_o,
    output logic [2:0] nxt_uid_o,
    output logic [3:0] nxt_cnt_o
);
    typedef struct packed {
        logic       valid;
        logic [6:0] rtaddr;
        logic [2:0] uid;
        logic [2:0] age;
    } slot_t;

    slot_t      slot_q  [DEPTH];
    slot_t      slot_d  [DEPTH];
    slot_t      shift_s [DEPTH];
    logic [2:0] lat_s;
    logic       free_s;
    logic [3:0] cnt_s;

    function automatic logic [2:0] latency(input logic [2:0] uid);
        logic [2:0] l;
        case (uid)
            3'd0:    l = 3'd2;
            3'd1:    l = 3'd6;
            3'd2:    l = 3'd4;
            3'd3:    l = 3'd4;
            3'd4:    l = 3'd6;
            3'd5:    l = 3'd4;
            3'd6:    l = 3'd2;
            default: l = 3'd0;
        endcase
        return l;
    endfunction

    // Ages the entry by one cycle; a flush kills it if its new age is still young.
    function automatic slot_t advance(input slot_t s, input logic flush);
        slot_t r;
        r     = s;
        r.age = (s.age == 3'd7) ? 3'd7 : s.age + 3'd1;
        if (!s.valid || (flush && (int'(r.age) < FLUSH_AGE))) begin
            r = '0;
        end else begin
            r.valid = 1'b1;
        end
        return r;
    endfunction

    // Shift toward slot 0, decide acceptance against the post-shift image, insert.
    always_comb begin
        lat_s  = latency(uid_i);
        free_s = 1'b0;
        cnt_s  = 4'd0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            shift_s[i] = advance(slot_q[i+1], flush_i);
        end
        shift_s[DEPTH-1] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_s = free_s | ((i == int'(lat_s) - 1) && !shift_s[i].valid);
        end
        ready_o = valid_i && !flush_i && !rst && ((lat_s == 3'd0) || free_s);
        for (int i = 0; i < DEPTH; i++) begin
            if (ready_o && (i == int'(lat_s) - 1)) begin
                slot_d[i] = {1'b1, rtaddr_i, uid_i, 3'd0};
            end else begin
                slot_d[i] = shift_s[i];
            end
            cnt_s = cnt_s + {3'd0, slot_d[i].valid};
        end
    end

    assign nxt_valid_o  = slot_d[0].valid;
    assign nxt_rtaddr_o = slot_d[0].rtaddr;
    assign nxt_uid_o    = slot_d[0].uid;
    assign nxt_cnt_o    = cnt_s;

    // Slot storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end
endmodule

module ff_ctrl #(
    parameter int DEPTH     = 7,
    parameter int FLUSH_AGE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_e_valid,
    input  logic [6:0] issue_e_rtaddr,
    input  logic [2:0] issue_e_uid,
    output logic       issue_e_ready,
    input  logic       issue_o_valid,
    input  logic [6:0] issue_o_rtaddr,
    input  logic [2:0] issue_o_uid,
    output logic       issue_o_ready,
    input  logic       flush,
    output logic       wb_e_en,
    output logic [6:0] wb_e_rtaddr,
    output logic [2:0] wb_e_uid,
    output logic       wb_o_en,
    output logic [6:0] wb_o_rtaddr,
    output logic [2:0] wb_o_uid,
    output logic [3:0] inflight_cnt,
    output logic       busy
);
    logic       e_nv_s, o_nv_s;
    logic [6:0] e_nrt_s, o_nrt_s;
    logic [2:0] e_nuid_s, o_nuid_s;
    logic [3:0] e_ncnt_s, o_ncnt_s;

    logic       wb_e_en_d, wb_e_en_q, wb_o_en_q;
    logic [6:0] wb_e_rt_q, wb_o_rt_q;
    logic [2:0] wb_e_uid_q, wb_o_uid_q;
    logic [3:0] cnt_d, cnt_q;
    logic       busy_q;

    ff_ctrl_pipe #(.DEPTH(DEPTH), .FLUSH_AGE(FLUSH_AGE)) u_even (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .valid_i      (issue_e_valid),
        .rtaddr_i     (issue_e_rtaddr),
        .uid_i        (issue_e_uid),
        .ready_o      (issue_e_ready),
        .nxt_valid_o  (e_nv_s),
        .nxt_rtaddr_o (e_nrt_s),
        .nxt_uid_o    (e_nuid_s),
        .nxt_cnt_o    (e_ncnt_s)
    );

    ff_ctrl_pipe #(.DEPTH(DEPTH), .FLUSH_AGE(FLUSH_AGE)) u_odd (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .valid_i      (issue_o_valid),
        .rtaddr_i     (issue_o_rtaddr),
        .uid_i        (issue_o_uid),
        .ready_o      (issue_o_ready),
        .nxt_valid_o  (o_nv_s),
        .nxt_rtaddr_o (o_nrt_s),
        .nxt_uid_o    (o_nuid_s),
        .nxt_cnt_o    (o_ncnt_s)
    );

    // Same-register writes in one cycle: the odd pipe holds the younger result.
    always_comb begin
        wb_e_en_d = e_nv_s;
        if (e_nv_s && o_nv_s && (e_nrt_s == o_nrt_s)) begin
            wb_e_en_d = 1'b0;
        end else begin
            wb_e_en_d = e_nv_s;
        end
        cnt_d = e_ncnt_s + o_ncnt_s;
    end

    // Writeback port and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_e_en_q  <= 1'b0;
            wb_e_rt_q  <= 7'd0;
            wb_e_uid_q <= 3'd0;
            wb_o_en_q  <= 1'b0;
            wb_o_rt_q  <= 7'd0;
            wb_o_uid_q <= 3'd0;
            cnt_q      <= 4'd0;
            busy_q     <= 1'b0;
        end else begin
            wb_e_en_q  <= wb_e_en_d;
            wb_e_rt_q  <= e_nrt_s;
            wb_e_uid_q <= e_nuid_s;
            wb_o_en_q  <= o_nv_s;
            wb_o_rt_q  <= o_nrt_s;
            wb_o_uid_q <= o_nuid_s;
            cnt_q      <= cnt_d;
            busy_q     <= (cnt_d != 4'd0);
        end
    end

    assign wb_e_en      = wb_e_en_q;
    assign wb_e_rtaddr  = wb_e_rt_q;
    assign wb_e_uid     = wb_e_uid_q;
    assign wb_o_en      = wb_o_en_q;
    assign wb_o_rtaddr  = wb_o_rt_q;
    assign wb_o_uid     = wb_o_uid_q;
    assign inflight_cnt = cnt_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_ff_ctrl.sv
// Self-checking bench for ff_ctrl: directed scenarios plus random traffic against
// a model that tracks each in-flight result by its accept and writeback cycle.
module tb_ff_ctrl;
    localparam int DEPTH     = 7;
    localparam int FLUSH_AGE = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_e_valid, issue_o_valid, issue_e_ready, issue_o_ready;
    logic [6:0] issue_e_rtaddr, issue_o_rtaddr, wb_e_rtaddr, wb_o_rtaddr;
    logic [2:0] issue_e_uid, issue_o_uid, wb_e_uid, wb_o_uid;
    logic       flush, wb_e_en, wb_o_en, busy;
    logic [3:0] inflight_cnt;

    ff_ctrl #(.DEPTH(DEPTH), .FLUSH_AGE(FLUSH_AGE)) dut (
        .clk(clk), .rst(rst),
        .issue_e_valid(issue_e_valid), .issue_e_rtaddr(issue_e_rtaddr),
        .issue_e_uid(issue_e_uid), .issue_e_ready(issue_e_ready),
        .issue_o_valid(issue_o_valid), .issue_o_rtaddr(issue_o_rtaddr),
        .issue_o_uid(issue_o_uid), .issue_o_ready(issue_o_ready),
        .flush(flush),
        .wb_e_en(wb_e_en), .wb_e_rtaddr(wb_e_rtaddr), .wb_e_uid(wb_e_uid),
        .wb_o_en(wb_o_en), .wb_o_rtaddr(wb_o_rtaddr), .wb_o_uid(wb_o_uid),
        .inflight_cnt(inflight_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pipe;
        int rt;
        int uid;
        int acc;
        int wb;
    } ent_t;

    ent_t mq[$];
    int   lat_tab[8] = '{2, 6, 4, 4, 6, 4, 2, 0};
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic s_wb_en[2], x_wb_en[2], s_ready[2], x_ready[2];
    int   s_wb_rt[2], x_wb_rt[2], s_wb_uid[2], x_wb_uid[2];
    int   s_cnt, x_cnt;
    logic s_busy, x_busy;

    // Expected outputs for the current cycle from the in-flight list.
    task automatic model_eval();
        logic vld[2];
        int   uid[2];
        vld[0] = issue_e_valid;  uid[0] = int'(issue_e_uid);
        vld[1] = issue_o_valid;  uid[1] = int'(issue_o_uid);
        if (rst) mq.delete();
        x_cnt = 0;
        for (int p = 0; p < 2; p++) begin
            x_wb_en[p] = 1'b0; x_wb_rt[p] = 0; x_wb_uid[p] = 0;
        end
        foreach (mq[k]) begin
            if (mq[k].wb == cyc) begin
                x_wb_en[mq[k].pipe]  = 1'b1;
                x_wb_rt[mq[k].pipe]  = mq[k].rt;
                x_wb_uid[mq[k].pipe] = mq[k].uid;
            end
            if (mq[k].acc < cyc && cyc <= mq[k].wb) x_cnt++;
        end
        if (x_wb_en[0] && x_wb_en[1] && x_wb_rt[0] == x_wb_rt[1]) x_wb_en[0] = 1'b0;
        x_busy = (x_cnt != 0);
        for (int p = 0; p < 2; p++) begin
            int  l;
            logic clash;
            l = lat_tab[uid[p]];
            clash = 1'b0;
            foreach (mq[k]) if (mq[k].pipe == p && mq[k].wb == cyc + l) clash = 1'b1;
            x_ready[p] = !rst && vld[p] && !flush && (l == 0 || !clash);
        end
    endtask

    // Clock-edge effects on the in-flight list.
    task automatic model_advance();
        int rt[2];
        int uid[2];
        rt[0] = int'(issue_e_rtaddr); uid[0] = int'(issue_e_uid);
        rt[1] = int'(issue_o_rtaddr); uid[1] = int'(issue_o_uid);
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                if (x_ready[p] && uid[p] != 7)
                    mq.push_back('{p, rt[p], uid[p], cyc, cyc + lat_tab[uid[p]]});
            end
            for (int k = mq.size() - 1; k >= 0; k--) begin
                int age;
                age = (cyc - mq[k].acc > 7) ? 7 : cyc - mq[k].acc;
                if (mq[k].wb <= cyc) mq.delete(k);
                else if (flush && age < FLUSH_AGE) mq.delete(k);
            end
        end
        cyc++;
    endtask

    task automatic tick(input logic ev, input int ert, input int eu,
                        input logic ov, input int ort, input int ou,
                        input logic fl, input logic r);
        issue_e_valid = ev; issue_e_rtaddr = 7'(ert); issue_e_uid = 3'(eu);
        issue_o_valid = ov; issue_o_rtaddr = 7'(ort); issue_o_uid = 3'(ou);
        flush = fl; rst = r;
        @(negedge clk);
        model_eval();
        s_wb_en[0] = wb_e_en; s_wb_rt[0] = int'(wb_e_rtaddr); s_wb_uid[0] = int'(wb_e_uid);
        s_wb_en[1] = wb_o_en; s_wb_rt[1] = int'(wb_o_rtaddr); s_wb_uid[1] = int'(wb_o_uid);
        s_ready[0] = issue_e_ready; s_ready[1] = issue_o_ready;
        s_cnt = int'(inflight_cnt); s_busy = busy;
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        tick(1'b1, 3, 0, 1'b1, 4, 2, 1'b0, 1'b1);
        total++; if (s_ready[0] !== 1'b0 || s_ready[1] !== 1'b0) begin bad++;
            $display("FAIL reset_ready: got %0b/%0b want 0/0", s_ready[0], s_ready[1]); end
        total++; if (s_wb_en[0] !== 1'b0 || s_wb_en[1] !== 1'b0) begin bad++;
            $display("FAIL reset_wb_en: got %0b/%0b want 0/0", s_wb_en[0], s_wb_en[1]); end
        total++; if (s_cnt !== 0 || s_busy !== 1'b0) begin bad++;
            $display("FAIL reset_cnt: got cnt=%0d busy=%0b want 0/0", s_cnt, s_busy); end
        idle(1);
    endtask

    task automatic test_single_wb();
        logic exp_en[3] = '{1'b0, 1'b1, 1'b0};
        int   exp_cnt[3] = '{1, 1, 0};
        idle(8);
        tick(1'b1, 5, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        total++; if (s_ready[0] !== 1'b1) begin bad++;
            $display("FAIL single_ready: got %0b want 1", s_ready[0]); end
        for (int k = 0; k < 3; k++) begin
            idle(1);
            total++; if (s_wb_en[0] !== exp_en[k] || s_cnt !== exp_cnt[k]) begin bad++;
                $display("FAIL single_c%0d: got en=%0b cnt=%0d want en=%0b cnt=%0d",
                         k + 1, s_wb_en[0], s_cnt, exp_en[k], exp_cnt[k]); end
            if (exp_en[k]) begin
                total++; if (s_wb_rt[0] !== 5) begin bad++;
                    $display("FAIL single_rt: got %0d want 5", s_wb_rt[0]); end
            end
        end
    endtask

    task automatic test_stall();
        idle(8);
        tick(1'b1, 9, 1, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(1);
        tick(1'b1, 10, 5, 1'b0, 0, 0, 1'b0, 1'b0);
        total++; if (s_ready[0] !== 1'b0) begin bad++;
            $display("FAIL stall_c2_ready: got %0b want 0", s_ready[0]); end
        tick(1'b1, 10, 5, 1'b0, 0, 0, 1'b0, 1'b0);
        total++; if (s_ready[0] !== 1'b1) begin bad++;
            $display("FAIL stall_c3_ready: got %0b want 1", s_ready[0]); end
        for (int c = 4; c <= 8; c++) begin
            int want_rt;
            idle(1);
            want_rt = (c == 6) ? 9 : (c == 7) ? 10 : -1;
            total++;
            if (s_wb_en[0] !== (want_rt >= 0) || (want_rt >= 0 && s_wb_rt[0] !== want_rt)) begin
                bad++;
                $display("FAIL stall_c%0d: got en=%0b rt=%0d want en=%0b rt=%0d",
                         c, s_wb_en[0], s_wb_rt[0], want_rt >= 0, want_rt);
            end
        end
    endtask

    task automatic test_waw();
        idle(8);
        tick(1'b1, 7, 2, 1'b1, 7, 3, 1'b0, 1'b0);
        total++; if (s_ready[0] !== 1'b1 || s_ready[1] !== 1'b1) begin bad++;
            $display("FAIL waw_ready: got %0b/%0b want 1/1", s_ready[0], s_ready[1]); end
        idle(4);
        total++; if (s_wb_o_ok() !== 1'b1 || s_wb_en[0] !== 1'b0) begin bad++;
            $display("FAIL waw_wb: got e=%0b o=%0b ort=%0d want e=0 o=1 ort=7",
                     s_wb_en[0], s_wb_en[1], s_wb_rt[1]); end
    endtask

    function automatic logic s_wb_o_ok();
        return s_wb_en[1] && (s_wb_rt[1] == 7);
    endfunction

    task automatic test_flush();
        idle(8);
        tick(1'b0, 0, 0, 1'b1, 20, 4, 1'b0, 1'b0);
        idle(3);
        tick(1'b1, 21, 6, 1'b0, 0, 0, 1'b0, 1'b0);
        total++; if (s_ready[0] !== 1'b1) begin bad++;
            $display("FAIL flush_c4_ready: got %0b want 1", s_ready[0]); end
        tick(1'b1, 22, 0, 1'b1, 23, 0, 1'b1, 1'b0);
        total++; if (s_ready[0] !== 1'b0 || s_ready[1] !== 1'b0) begin bad++;
            $display("FAIL flush_ready: got %0b/%0b want 0/0", s_ready[0], s_ready[1]); end
        idle(1);
        total++; if (s_wb_en[1] !== 1'b1 || s_wb_rt[1] !== 20 || s_wb_en[0] !== 1'b0) begin bad++;
            $display("FAIL flush_c6: got o=%0b ort=%0d e=%0b want o=1 ort=20 e=0",
                     s_wb_en[1], s_wb_rt[1], s_wb_en[0]); end
        idle(1);
        total++; if (s_cnt !== 0 || s_wb_en[0] !== 1'b0) begin bad++;
            $display("FAIL flush_c7: got cnt=%0d e=%0b want 0/0", s_cnt, s_wb_en[0]); end
    endtask

    task automatic test_reset_mid();
        idle(8);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 0, 0, 1'b1, 30 + k, 6, 1'b0, (k >= 3));
            if (k >= 3) begin
                total++;
                if (s_wb_en[0] !== 1'b0 || s_wb_en[1] !== 1'b0 || s_cnt !== 0 ||
                    s_busy !== 1'b0 || s_ready[1] !== 1'b0) begin
                    bad++;
                    $display("FAIL rstmid_c%0d: got wb=%0b/%0b cnt=%0d busy=%0b rdy=%0b want all 0",
                             k, s_wb_en[0], s_wb_en[1], s_cnt, s_busy, s_ready[1]);
                end
            end
        end
        for (int k = 0; k < 6; k++) begin
            idle(1);
            total++; if (s_wb_en[1] !== 1'b0 || s_cnt !== 0) begin bad++;
                $display("FAIL rstmid_after%0d: got en=%0b cnt=%0d want 0/0", k, s_wb_en[1], s_cnt); end
        end
    endtask

    task automatic test_uid7();
        idle(8);
        tick(1'b1, 11, 7, 1'b1, 12, 7, 1'b0, 1'b0);
        total++; if (s_ready[0] !== 1'b1 || s_ready[1] !== 1'b1) begin bad++;
            $display("FAIL uid7_ready: got %0b/%0b want 1/1", s_ready[0], s_ready[1]); end
        for (int k = 0; k < 8; k++) begin
            idle(1);
            total++; if (s_cnt !== 0 || s_wb_en[0] !== 1'b0 || s_wb_en[1] !== 1'b0) begin bad++;
                $display("FAIL uid7_c%0d: got cnt=%0d en=%0b/%0b want 0", k, s_cnt, s_wb_en[0], s_wb_en[1]); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 7),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
            for (int p = 0; p < 2; p++) begin
                total++; if (s_ready[p] !== x_ready[p]) begin bad++;
                    $display("FAIL rnd_ready%0d @%0d: got %0b want %0b", p, cyc, s_ready[p], x_ready[p]); end
                total++; if (s_wb_en[p] !== x_wb_en[p]) begin bad++;
                    $display("FAIL rnd_wb_en%0d @%0d: got %0b want %0b", p, cyc, s_wb_en[p], x_wb_en[p]); end
                total++; if (s_wb_rt[p] !== x_wb_rt[p] || s_wb_uid[p] !== x_wb_uid[p]) begin bad++;
                    $display("FAIL rnd_wb_tag%0d @%0d: got rt=%0d uid=%0d want rt=%0d uid=%0d",
                             p, cyc, s_wb_rt[p], s_wb_uid[p], x_wb_rt[p], x_wb_uid[p]); end
            end
            total++; if (s_cnt !== x_cnt || s_busy !== x_busy) begin bad++;
                $display("FAIL rnd_cnt @%0d: got cnt=%0d busy=%0b want cnt=%0d busy=%0b",
                         cyc, s_cnt, s_busy, x_cnt, x_busy); end
        end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0;
        issue_e_valid = 1'b0; issue_e_rtaddr = 7'd0; issue_e_uid = 3'd0;
        issue_o_valid = 1'b0; issue_o_rtaddr = 7'd0; issue_o_uid = 3'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_wb();
        test_stall();
        test_waw();
        test_flush();
        test_reset_mid();
        test_uid7();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ff_ctrl.md
FF_CTRL -- requirements
Module: ff_ctrl

Interface
REQ-001 Parameter DEPTH, default 7: number of forwarding-stage slots tracked per pipe (max latency).
REQ-002 Parameter FLUSH_AGE, default 2: entries younger than this many cycles are killed on flush.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset (`RST_ENABLE).
REQ-005 issue_e_valid  input  1  even-pipe instruction offered for writeback tracking.
REQ-006 issue_e_rtaddr  input  [0:6]  even-pipe destination register.
REQ-007 issue_e_uid  input  [0:2]  even-pipe execution unit id.
REQ-008 issue_e_ready  output  1  even-pipe offer accepted this cycle.
REQ-009 issue_o_valid / issue_o_rtaddr [0:6] / issue_o_uid [0:2] / issue_o_ready: odd-pipe equivalents, same directions.
REQ-010 flush  input  1  taken branch resolved; kill young in-flight entries.
REQ-011 wb_e_en  output  1  even register-file write enable.
REQ-012 wb_e_rtaddr  output  [0:6] / wb_e_uid  output  [0:2]  even writeback tag.
REQ-013 wb_o_en / wb_o_rtaddr [0:6] / wb_o_uid [0:2]  outputs: odd writeback tag.
REQ-014 inflight_cnt  output  [0:3]  valid entries across both pipes (0..2*DEPTH).
REQ-015 busy  output  1  inflight_cnt nonzero.

Function
REQ-016 Each pipe SHALL hold DEPTH slots {valid, rtaddr[0:6], uid[0:2], age[0:2]}; slot 0 is the writeback slot.
REQ-017 Latency L by uid SHALL be: 0->2, 1->6, 2->4, 3->4, 4->6, 5->4, 6->2; uid 7 has no writeback (L=0).
REQ-018 Every cycle all slots SHALL shift one position toward slot 0; slot 0 content leaves the block.
REQ-019 wb_x_en SHALL equal slot-0 valid of pipe x (registered); wb_x_rtaddr/uid SHALL be slot-0 fields, zero when invalid.
REQ-020 An offer SHALL be accepted (ready=1) iff valid=1, flush=0, and slot L-1 is empty after the shift; accepted entry lands in slot L-1 with age 0.
REQ-021 uid 7 offers SHALL be accepted whenever flush=0 and create no entry.
REQ-022 ready SHALL be combinational from current state, valid, uid and flush; ready=0 means the issuer holds the offer (stall).
REQ-023 age SHALL increment by 1 per cycle, saturating at 7.
REQ-024 When flush=1, entries with age < FLUSH_AGE SHALL be invalidated in the same edge that shifts; entries at slot 0 already driving wb SHALL NOT be suppressed.
REQ-025 WAW: if wb_e_en and wb_o_en are both 1 with equal rtaddr, wb_e_en SHALL be forced 0 (odd is younger and wins).
REQ-026 inflight_cnt SHALL be registered and equal the post-update valid-slot count; busy = (inflight_cnt != 0).
REQ-027 Simultaneous accept on both pipes SHALL be allowed; pipes are independent except REQ-025.

Reset
REQ-028 While rst=1, all slots invalid, all fields 0, wb_* = 0, inflight_cnt = 0, busy = 0, asynchronously.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight entries with no writeback emitted.
REQ-030 ready SHALL be 0 while rst=1.

Verification
REQ-031 Even issue uid=0 rt=5 at cycle 0 -> wb_e_en=1, wb_e_rtaddr=5 at cycle 2 only; inflight_cnt 1 then 0.
REQ-032 Even uid=1 rt=9 at cycle 0, even uid=5 rt=10 at cycle 2 -> cycle-2 offer ready=0 (slot 3 taken); offer retried cycle 3 accepted, wb rt=9 at cycle 6, rt=10 at cycle 7.
REQ-033 Even uid=2 rt=7 and odd uid=3 rt=7 same cycle -> at cycle+4 wb_o_en=1 rt=7, wb_e_en=0.
REQ-034 Odd uid=4 at cycle 0, even uid=6 at cycle 4, flush=1 at cycle 5 -> even entry (age 1) killed, odd entry (age 5) writes back at cycle 6; flush-cycle offers ready=0.
REQ-035 Fill odd pipe with uid=6 every cycle for 5 cycles, assert rst at cycle 3 -> all wb_* 0, inflight_cnt 0 immediately, no writeback after release.
REQ-036 uid=7 offer with empty pipes -> ready=1, inflight_cnt stays 0, no wb.
